// File: rtl/wb_core_bridge.sv
// Ibex native memory port (req/gnt/rvalid) to Wishbone B4 pipelined master bridge.
// Counts outstanding transfers to hold CYC, and registers responses back to the core.
module wb_core_bridge #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           push_idx;
  logic [MAX_OUTSTANDING-1:0] we_fifo;
  logic [MAX_OUTSTANDING-1:0] we_fifo_nxt;
  logic                       cnt_nz;
  logic                       term;

  // Request stage (combinational pass-through to the bus)
  assign cnt_nz     = (cnt != '0);
  assign term       = (wb_ack_i | wb_err_i) & cnt_nz;
  assign wb_stb_o   = core_req_i & (cnt < CNT_MAX);
  assign core_gnt_o = wb_stb_o & ~wb_stall_i;
  assign wb_cyc_o   = wb_stb_o | cnt_nz;
  assign wb_we_o    = core_we_i;
  assign wb_sel_o   = core_be_i;
  assign wb_dat_o   = core_wdata_i;
  assign wb_adr_o   = core_addr_i & ~32'h3;

  // Oldest entry sits at bit 0; a pop shifts down, so a same-cycle push lands one slot lower.
  always_comb begin
    we_fifo_nxt = term ? (we_fifo >> 1) : we_fifo;
    push_idx    = term ? (cnt - CNT_W'(1)) : cnt;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (core_gnt_o && (push_idx == CNT_W'(i))) begin
        we_fifo_nxt[i] = core_we_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      we_fifo <= '0;
    end else begin
      we_fifo <= we_fifo_nxt;
      case ({core_gnt_o, term})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Response stage (one registered cycle after termination)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rvalid_o <= 1'b0;
      core_err_o    <= 1'b0;
      core_rdata_o  <= '0;
    end else begin
      core_rvalid_o <= term;
      core_err_o    <= term & wb_err_i;
      if (term && !wb_err_i && !we_fifo[0]) begin
        core_rdata_o <= wb_dat_i;
      end
    end
  end

endmodule
